demultiplexador_04: RTL

Registered 1-to-4 data distributor: accepts a 32-bit word with a 2-bit destination select from the control unit and delivers it to one of four sink channels, or all four in broadcast mode. It is the distribution counterpart of the 4-to-1 selection mux on the processor datapath: it feeds writeback and forwarding consumers that may stall. Each destination has a one-word holding slot with a valid/ready handshake, so a stalled sink blocks only writes aimed at it.

---
 rtl/demultiplexador_04_pkg.sv | 18 +
 rtl/demultiplexador_04_if.sv | 43 ++++
 rtl/demultiplexador_04_demux_slot.sv | 41 ++++
 rtl/demultiplexador_04.sv | 73 +++++++
 4 files changed

// File: rtl/demultiplexador_04_pkg.sv
// Shared types and constants for the 1-to-4 registered data distributor.
// Holds the default data width, channel select codes and slot state type.
// No logic; imported by the interface, slot and top.
package demultiplexador_04_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] CH1 = 2'b00;
    localparam logic [1:0] CH2 = 2'b01;
    localparam logic [1:0] CH3 = 2'b10;
    localparam logic [1:0] CH4 = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demultiplexador_04_if.sv
// Bundle of the distributor's producer side and four sink channels.
// master = producer/sinks driving the block, slave = the distributor itself.
// in_ready is combinational from slot state, sink readies and selects.
interface demultiplexador_04_if
    import demultiplexador_04_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);
    logic [1:0]       UC_demux04;
    logic             UC_broadcast;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out1;
    logic [WIDTH-1:0] data_out2;
    logic [WIDTH-1:0] data_out3;
    logic [WIDTH-1:0] data_out4;
    logic             valid_out1;
    logic             valid_out2;
    logic             valid_out3;
    logic             valid_out4;
    logic             ready_in1;
    logic             ready_in2;
    logic             ready_in3;
    logic             ready_in4;
    logic             busy;

    modport master (
        output UC_demux04, UC_broadcast, in_valid, data_in,
        output ready_in1, ready_in2, ready_in3, ready_in4,
        input  in_ready, busy,
        input  data_out1, data_out2, data_out3, data_out4,
        input  valid_out1, valid_out2, valid_out3, valid_out4
    );

    modport slave (
        input  UC_demux04, UC_broadcast, in_valid, data_in,
        input  ready_in1, ready_in2, ready_in3, ready_in4,
        output in_ready, busy,
        output data_out1, data_out2, data_out3, data_out4,
        output valid_out1, valid_out2, valid_out3, valid_out4
    );
endinterface

// File: rtl/demultiplexador_04_demux_slot.sv
// One-word holding slot for a single sink channel (EMPTY/FULL).
// Latency: written word visible one edge after the write.
// Backpressure: can_take while empty or while the sink drains this cycle.
module demux_slot
    import demultiplexador_04_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_can_take
);

    slot_state_t      r_state;
    logic [WIDTH-1:0] r_data;

    // Slot state: a write always wins (fill or drain-and-refill), otherwise drain on sink ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else begin
            if (i_wr) begin
                r_state <= FULL;
                r_data  <= i_data;
            end else if (i_ready) begin
                r_state <= EMPTY;
            end
        end
    end

    assign o_data     = r_data;
    assign o_valid    = (r_state == FULL);
    assign o_can_take = !o_valid || i_ready;

endmodule

// File: rtl/demultiplexador_04.sv
// Registered 1-to-4 distributor with unicast or all-channel broadcast.
// Latency: one edge from accept to data_outN/valid_outN.
// Backpressure: in_ready reflects only the targeted slot(s); broadcast needs all four.
module demultiplexador_04
    import demultiplexador_04_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    demultiplexador_04_if.slave  bus
);

    logic [3:0]       w_sel_hot;
    logic [3:0]       w_can_take;
    logic [3:0]       w_valid;
    logic [3:0]       w_ready_in;
    logic [3:0]       w_wr;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_data [4];

    assign w_ready_in = {bus.ready_in4, bus.ready_in3, bus.ready_in2, bus.ready_in1};

    // Decode the unicast destination into a one-hot channel mask.
    always_comb begin
        w_sel_hot = 4'b0000;
        case (bus.UC_demux04)
            CH1:     w_sel_hot[0] = 1'b1;
            CH2:     w_sel_hot[1] = 1'b1;
            CH3:     w_sel_hot[2] = 1'b1;
            CH4:     w_sel_hot[3] = 1'b1;
            default: w_sel_hot = 4'b0000;
        endcase
    end

    // Broadcast is all-or-nothing, so it needs every slot able to take the word.
    always_comb begin
        if (bus.UC_broadcast) begin
            w_in_ready = &w_can_take;
        end else begin
            w_in_ready = |(w_can_take & w_sel_hot);
        end
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_wr     = {4{w_accept}} & (bus.UC_broadcast ? 4'b1111 : w_sel_hot);

    for (genvar n = 0; n < 4; n++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clock      (clock),
            .reset      (reset),
            .i_wr       (w_wr[n]),
            .i_data     (bus.data_in),
            .i_ready    (w_ready_in[n]),
            .o_data     (w_data[n]),
            .o_valid    (w_valid[n]),
            .o_can_take (w_can_take[n])
        );
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.busy       = |w_valid;
    assign bus.data_out1  = w_data[0];
    assign bus.data_out2  = w_data[1];
    assign bus.data_out3  = w_data[2];
    assign bus.data_out4  = w_data[3];
    assign bus.valid_out1 = w_valid[0];
    assign bus.valid_out2 = w_valid[1];
    assign bus.valid_out3 = w_valid[2];
    assign bus.valid_out4 = w_valid[3];

endmodule
